// File: rtl/painterengine_gpu_fill_source.sv
// rtl/painterengine_gpu_fill_source.sv - solid/gradient ARGB word source feeding one lane of the gpu dma writer
// Emits `length` words starting at `color`, adding `step` per byte lane (mod 256) on every accepted word.
module painterengine_gpu_fill_source #(
  parameter logic [31:0] PARAM_MAX_LENGTH = 32'h0010_0000
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic        i_wire_start,
  input  logic [31:0] i_wire_color,
  input  logic [31:0] i_wire_step,
  input  logic [31:0] i_wire_length,
  output logic [31:0] o_wire_data,
  output logic        o_wire_data_valid,
  input  logic        i_wire_data_next,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [31:0] o_wire_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_STREAM = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] color_r;
  logic [31:0] step_r;
  logic [31:0] length_r;
  logic [31:0] remaining;
  logic [31:0] data_step;
  logic        xfer;
  logic        len_bad;

  assign xfer    = o_wire_data_valid && i_wire_data_next;
  assign len_bad = (length_r == 32'd0) || (length_r > PARAM_MAX_LENGTH);

  // Independent byte lanes: no carry crosses a lane boundary.
  always_comb begin
    data_step = '0;
    for (int i = 0; i < 4; i++) begin
      data_step[8*i +: 8] = o_wire_data[8*i +: 8] + step_r[8*i +: 8];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (i_wire_start) state_next = S_CHECK;
      S_CHECK:  state_next = len_bad ? S_ERROR : S_STREAM;
      S_STREAM: if (xfer && remaining == 32'd1) state_next = S_DONE;
      S_DONE:   if (!i_wire_start) state_next = S_IDLE;
      S_ERROR:  if (!i_wire_start) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      color_r           <= '0;
      step_r            <= '0;
      length_r          <= '0;
      remaining         <= '0;
      o_wire_data       <= '0;
      o_wire_data_valid <= 1'b0;
      o_wire_done       <= 1'b0;
      o_wire_error      <= 1'b0;
      o_wire_count      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_wire_start) begin
            color_r      <= i_wire_color;
            step_r       <= i_wire_step;
            length_r     <= i_wire_length;
            o_wire_count <= '0;
          end
        end
        S_CHECK: begin
          if (len_bad) begin
            o_wire_error <= 1'b1;
            o_wire_count <= '0;
          end else begin
            o_wire_data       <= color_r;
            remaining         <= length_r;
            o_wire_data_valid <= 1'b1;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            o_wire_data  <= data_step;
            o_wire_count <= o_wire_count + 32'd1;
            remaining    <= remaining - 32'd1;
            // Last word: drop valid on the accepting edge so nothing extra is presented.
            if (remaining == 32'd1) begin
              o_wire_data_valid <= 1'b0;
              o_wire_done       <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!i_wire_start) o_wire_done <= 1'b0;
        end
        S_ERROR: begin
          if (!i_wire_start) o_wire_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_fill_source.sv
// tb/tb_painterengine_gpu_fill_source.sv - directed self-checking bench for the fill source
module tb_painterengine_gpu_fill_source;

  localparam logic [31:0] MAXL = 32'h0010_0000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        next;
  logic [31:0] color;
  logic [31:0] step;
  logic [31:0] length;
  logic [31:0] data;
  logic [31:0] count;
  logic        valid;
  logic        done;
  logic        error;

  int n_cmp;
  int n_bad;
  logic [31:0] rx [0:15];

  painterengine_gpu_fill_source #(.PARAM_MAX_LENGTH(MAXL)) dut (
    .i_wire_clock      (clk),
    .i_wire_resetn     (rst_n),
    .i_wire_start      (start),
    .i_wire_color      (color),
    .i_wire_step       (step),
    .i_wire_length     (length),
    .o_wire_data       (data),
    .o_wire_data_valid (valid),
    .i_wire_data_next  (next),
    .o_wire_done       (done),
    .o_wire_error      (error),
    .o_wire_count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lanes(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = a[8*i +: 8] + b[8*i +: 8];
    return r;
  endfunction

  // Runs one request, leaves start high with the block in DONE.
  task automatic do_stream(input string nm, input logic [31:0] c, input logic [31:0] s,
                           input logic [31:0] l, input logic [7:0] pat, input int plen);
    logic [31:0] exp;
    int got;
    int cyc;
    @(negedge clk);
    color = c; step = s; length = l; start = 1'b1; next = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL %s_valid_in_check: got %b want 0", nm, valid);
    end
    color = ~c; step = ~s; length = 32'd7;
    exp = c; got = 0; cyc = 0;
    @(posedge clk);
    while (got < int'(l) && cyc < 200) begin
      @(negedge clk);
      n_cmp++;
      if (valid !== 1'b1 || data !== exp) begin
        n_bad++; $display("FAIL %s_word%0d: got v=%b d=%h want v=1 d=%h", nm, got, valid, data, exp);
      end
      next = pat[cyc % plen];
      if (next) begin
        if (got < 16) rx[got] = data;
        got++;
        exp = lanes(exp, s);
      end
      cyc++;
      @(posedge clk);
    end
    @(negedge clk);
    next = 1'b0;
    n_cmp++;
    if (cyc >= 200) begin
      n_bad++; $display("FAIL %s_timeout: got %0d words want %0d", nm, got, l);
    end
    n_cmp++;
    if (valid !== 1'b0 || done !== 1'b1 || count !== l) begin
      n_bad++; $display("FAIL %s_end: got v=%b done=%b cnt=%0d want v=0 done=1 cnt=%0d", nm, valid, done, count, l);
    end
  endtask

  task automatic drop_start(input string nm, input logic [31:0] held_count);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || error !== 1'b0 || count !== held_count) begin
      n_bad++; $display("FAIL %s_idle: got done=%b err=%b cnt=%0d want 0 0 %0d", nm, done, error, count, held_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; next = 1'b0; color = '0; step = '0; length = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0 || done !== 1'b0 || error !== 1'b0 || count !== 32'd0 || data !== 32'd0) begin
      n_bad++; $display("FAIL reset: got v=%b done=%b err=%b cnt=%h d=%h want all 0", valid, done, error, count, data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_solid();
    do_stream("solid", 32'hFF102030, 32'h0, 32'd4, 8'hFF, 1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rx[i] !== 32'hFF102030) begin
        n_bad++; $display("FAIL solid_rx%0d: got %h want ff102030", i, rx[i]);
      end
    end
    drop_start("solid", 32'd4);
  endtask

  task automatic test_gradient();
    logic [31:0] want [0:2];
    want[0] = 32'h00FE0001; want[1] = 32'h00FF0102; want[2] = 32'h00000203;
    do_stream("grad", 32'h00FE0001, 32'h00010101, 32'd3, 8'hFF, 1);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rx[i] !== want[i]) begin
        n_bad++; $display("FAIL grad_rx%0d: got %h want %h", i, rx[i], want[i]);
      end
    end
    drop_start("grad", 32'd3);
  endtask

  task automatic test_backpressure();
    do_stream("bp", 32'h10203040, 32'h01020304, 32'd5, 8'hD9, 8);
    n_cmp++;
    if (rx[4] !== 32'h14283C50) begin
      n_bad++; $display("FAIL bp_last: got %h want 14283c50", rx[4]);
    end
    drop_start("bp", 32'd5);
  endtask

  task automatic test_error(input string nm, input logic [31:0] l);
    @(negedge clk);
    length = l; start = 1'b1; next = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (error !== 1'b0 || valid !== 1'b0) begin
      n_bad++; $display("FAIL %s_check: got err=%b v=%b want 0 0", nm, error, valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (error !== 1'b1 || valid !== 1'b0 || count !== 32'd0) begin
        n_bad++; $display("FAIL %s_err%0d: got err=%b v=%b cnt=%0d want 1 0 0", nm, i, error, valid, count);
      end
    end
    next = 1'b0;
    drop_start(nm, 32'd0);
  endtask

  task automatic test_max_length();
    @(negedge clk);
    color = 32'h0; step = 32'h01010101; length = MAXL; start = 1'b1; next = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    next = 1'b1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (count !== 32'd1000 || valid !== 1'b1 || data !== 32'hE8E8E8E8 || error !== 1'b0) begin
      n_bad++; $display("FAIL max_len: got cnt=%0d v=%b d=%h err=%b want 1000 1 e8e8e8e8 0", count, valid, data, error);
    end
    next = 1'b0; start = 1'b0; rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_retrigger();
    do_stream("retrig_a", 32'hAA000000, 32'h00000010, 32'd2, 8'hFF, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (valid !== 1'b0 || done !== 1'b1 || count !== 32'd2) begin
        n_bad++; $display("FAIL retrig_hold%0d: got v=%b done=%b cnt=%0d want 0 1 2", i, valid, done, count);
      end
    end
    drop_start("retrig", 32'd2);
    do_stream("retrig_b", 32'h01020304, 32'h0, 32'd3, 8'hFF, 1);
    drop_start("retrig_b", 32'd3);
  endtask

  task automatic test_reset_mid_stream();
    @(negedge clk);
    color = 32'h0; step = 32'h1; length = 32'd8; start = 1'b1; next = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    next = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    next = 1'b0; start = 1'b0; rst_n = 1'b0;
    #1;
    n_cmp++;
    if (valid !== 1'b0 || count !== 32'd0 || done !== 1'b0 || data !== 32'd0) begin
      n_bad++; $display("FAIL rst_mid: got v=%b cnt=%0d done=%b d=%h want 0 0 0 0", valid, count, done, data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_stream("rst_after", 32'h00000000, 32'h00000001, 32'd8, 8'hFF, 1);
    n_cmp++;
    if (rx[7] !== 32'h00000007) begin
      n_bad++; $display("FAIL rst_after_last: got %h want 00000007", rx[7]);
    end
    drop_start("rst_after", 32'd8);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_solid();
    test_gradient();
    test_backpressure();
    test_error("err_zero", 32'd0);
    test_error("err_over", MAXL + 32'd1);
    test_max_length();
    test_retrigger();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/painterengine_gpu_fill_source.md
Name: painterengine_gpu_fill_source

Overview:
Upstream pixel source for one channel of painterengine_gpu_dma_writer's data port. On start, it streams `length` 32-bit ARGB words into the writer. The stream is either a solid colour or a per-lane linear gradient: each byte lane adds a step, wrapping mod 256. The outputs connect directly to one lane of the writer's i_wire_data / i_wire_data_valid / o_wire_data_next.

Parameters:
PARAM_MAX_LENGTH, 32'h0010_0000, largest legal word count; a larger request is an error.

Ports:
i_wire_clock  input  1  clock
i_wire_resetn  input  1  asynchronous active-low reset
i_wire_start  input  1  level request; sampled only in IDLE
i_wire_color  input  32  first word emitted, {A,R,G,B}
i_wire_step  input  32  per-lane increment {dA,dR,dG,dB}; 0 = solid fill
i_wire_length  input  32  number of words to emit
o_wire_data  output  32  current word
o_wire_data_valid  output  1  o_wire_data is valid
i_wire_data_next  input  1  consumer accepted the current word this cycle
o_wire_done  output  1  all words accepted
o_wire_error  output  1  illegal request
o_wire_count  output  32  words accepted so far in this request

Behaviour:
- One clock, i_wire_clock. Reset is asynchronous and active-low on i_wire_resetn. All state is clocked on the rising edge.
- Reset values: state=IDLE, o_wire_data=0, o_wire_data_valid=0, o_wire_done=0, o_wire_error=0, o_wire_count=0, internal remaining=0.
- States: IDLE, CHECK, STREAM, DONE, ERROR.
- IDLE:
  - When i_wire_start=1, latch color, step and length into internal registers, clear count, and go to CHECK.
  - Inputs are not sampled again until the next IDLE.
- CHECK (one cycle):
  - length==0 or length>PARAM_MAX_LENGTH -> ERROR.
  - Otherwise load o_wire_data=color, set remaining=length, set o_wire_data_valid=1, and go to STREAM.
  - First valid word appears 2 cycles after start is sampled.
- STREAM:
  - o_wire_data_valid=1 throughout.
  - A word is transferred in a cycle where data_valid && i_wire_data_next are both 1. i_wire_data_next while valid=0 is ignored.
  - On a transfer:
    - count+=1 and remaining-=1.
    - Each byte lane i updates independently: data[8i+:8] <= data[8i+:8] + step[8i+:8]. There is no carry between lanes; wrap is mod 256.
  - Zero-bubble: back-to-back next pulses consume one word per cycle. The next word is registered on the same edge.
  - Data stays stable while valid && !next, for any number of cycles. There is no timeout; stall detection is the writer's responsibility.
  - On the transfer with remaining==1, clear valid on that edge, set o_wire_done=1, and go to DONE. No extra word is ever presented.
- DONE:
  - o_wire_done=1 and o_wire_count holds the final value.
  - When i_wire_start=0, go to IDLE with done cleared; count is held until the next start.
- ERROR:
  - o_wire_error=1, valid=0, count=0.
  - When i_wire_start=0, go to IDLE.
- Start held high through DONE/ERROR does not retrigger. A new request requires start to fall and rise again (a level seen in IDLE).
- Input changes to color/step/length mid-request have no effect.
- Reset asserted mid-STREAM:
  - Valid drops immediately (asynchronously) and all registers return to reset values.
  - The partial transfer is abandoned. The writer is reset by the same net.
- Width rules:
  - count and remaining are 32-bit.
  - Comparison with PARAM_MAX_LENGTH is unsigned.
  - length==PARAM_MAX_LENGTH is legal.
- Combinational paths: none from i_wire_data_next to any output. All outputs are registered.

Test Plan:
- Solid fill: color=32'hFF102030, step=0, length=4, next tied 1 -> valid for exactly 4 cycles starting 2 cycles after start, data=FF102030 each cycle; done=1 after; count=4.
- Gradient with wrap: color=32'h00FE0001, step=32'h00010101, length=3, next=1 -> data sequence 00FE0001, 00FF0102, 00000203; lanes wrap with no carry; done, count=3.
- Backpressure: length=5, next pattern 1,0,0,1,1,0,1,1 -> data holds stable during next=0; exactly 5 words transferred in order; valid falls on the edge of the 5th accept.
- Errors: length=0 -> error=1 one cycle after CHECK, valid never rises; length=PARAM_MAX_LENGTH+1 -> error; length=PARAM_MAX_LENGTH -> streams normally (spot-check count after 1000 words).
- Retrigger/reset: start held high after done -> no second stream; drop start, raise again -> new stream. Assert resetn low after 2 of 8 words -> valid=0 immediately, count=0, state IDLE; a following start produces a full 8-word stream.
